lbp_stream_engine: RTL and testbench

//  Parametrised LBP engine: reads a grey image once in raster order via req/ready, keeps two line

---
 rtl/lbp_stream_engine.sv | 193 +++++++++++++++++++
 tb/tb_lbp_stream_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_stream_engine.sv
// lbp_stream_engine: reads a grey image once in raster order and writes one 8-bit LBP code per interior pixel.
// Latency: the code for centre (r-1,c-1) is presented exactly one cycle after pixel (r,c) is accepted.
// Backpressure: gray_ready low stalls address, window and output; border write-back ignores gray_ready.
module lbp_stream_engine #(
  parameter int IMG_W        = 128,
  parameter int IMG_H        = 128,
  parameter int PIX_W        = 8,
  parameter int ADDR_W       = 14,
  parameter int BORDER_WRITE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [PIX_W-1:0]  gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  // Column and row counters only need to index 0..IMG_W-1 / 0..IMG_H-1.
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_BORDER = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
  // Offset from the newest pixel (r,c) back to the window centre (r-1,c-1).
  localparam logic [ADDR_W-1:0] CENTRE_OFS = ADDR_W'(IMG_W + 1);
  // Jump from column 0 to column W-1 on a middle border row.
  localparam logic [ADDR_W-1:0] SIDE_STEP  = ADDR_W'(IMG_W - 1);
  localparam logic [CW-1:0]     COL_ONE    = CW'(1);
  localparam logic [CW-1:0]     COL_TWO    = CW'(2);
  localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_ONE    = RW'(1);
  localparam logic [RW-1:0]     ROW_TWO    = RW'(2);
  localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H - 1);

  logic [1:0]        state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              accept;
  logic              last_pix;
  logic              emit;

  // Line buffers: lb_top holds row r-2, lb_mid holds row r-1, indexed by column.
  logic [PIX_W-1:0]  lb_top [IMG_W];
  logic [PIX_W-1:0]  lb_mid [IMG_W];
  logic [PIX_W-1:0]  col_top;
  logic [PIX_W-1:0]  col_mid;

  // Window: the two columns to the left of the incoming column (c-2 and c-1).
  logic [PIX_W-1:0]  top_l, top_c;
  logic [PIX_W-1:0]  mid_l, mid_c;
  logic [PIX_W-1:0]  bot_l, bot_c;
  logic [7:0]        code;

  // Border walk state.
  logic [RW-1:0]     b_row;
  logic [CW-1:0]     b_col;
  logic [ADDR_W-1:0] b_addr;
  logic              b_full_row;
  logic              b_last;

  assign gray_req   = (state == S_READ);
  assign accept     = gray_req && gray_ready;
  assign last_pix   = (gray_addr == LAST_ADDR);
  assign emit       = accept && (row >= ROW_TWO) && (col >= COL_TWO);
  assign col_top    = lb_top[col];
  assign col_mid    = lb_mid[col];
  assign b_full_row = (b_row == '0) || (b_row == ROW_LAST);
  assign b_last     = (b_row == ROW_LAST) && (b_col == COL_LAST);

  // LBP code for the window completed by the pixel currently on gray_data; centre is mid_c.
  always_comb begin
    code    = 8'h00;
    code[0] = (top_l   >= mid_c);
    code[1] = (top_c   >= mid_c);
    code[2] = (col_top >= mid_c);
    code[3] = (mid_l   >= mid_c);
    code[4] = (col_mid >= mid_c);
    code[5] = (bot_l   >= mid_c);
    code[6] = (bot_c   >= mid_c);
    code[7] = (gray_data >= mid_c);
  end

  // Control FSM: wait for the source, stream the frame, optionally paint borders, then park.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (gray_ready) state <= S_READ;
        S_READ:   if (accept && last_pix) state <= (BORDER_WRITE != 0) ? S_BORDER : S_DONE;
        S_BORDER: if (b_last) state <= S_DONE;
        default:  state <= S_DONE;
      endcase
    end
  end

  // Read pointer and raster position advance only on an accepted pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_addr <= '0;
      row       <= '0;
      col       <= '0;
    end else if (accept) begin
      if (last_pix) begin
        gray_addr <= '0;
        row       <= '0;
        col       <= '0;
      end else begin
        gray_addr <= gray_addr + ADDR_ONE;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_ONE;
        end else begin
          col <= col + COL_ONE;
        end
      end
    end
  end

  // Line buffers and window shift on acceptance; contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col] <= col_mid;
      lb_mid[col] <= gray_data;
      top_l       <= top_c;
      top_c       <= col_top;
      mid_l       <= mid_c;
      mid_c       <= col_mid;
      bot_l       <= bot_c;
      bot_c       <= gray_data;
    end
  end

  // Border walk: full first/last rows, only columns 0 and W-1 on the rows between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_row  <= '0;
      b_col  <= '0;
      b_addr <= '0;
    end else if (state == S_BORDER) begin
      if (b_col == COL_LAST) begin
        b_col  <= '0;
        b_row  <= b_row + ROW_ONE;
        b_addr <= b_addr + ADDR_ONE;
      end else if (b_full_row) begin
        b_col  <= b_col + COL_ONE;
        b_addr <= b_addr + ADDR_ONE;
      end else begin
        b_col  <= COL_LAST;
        b_addr <= b_addr + SIDE_STEP;
      end
    end
  end

  // Result port: interior codes one cycle after acceptance, then zero words during the border walk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
    end else if (emit) begin
      lbp_valid <= 1'b1;
      lbp_addr  <= gray_addr - CENTRE_OFS;
      lbp_data  <= code;
    end else if (state == S_BORDER) begin
      lbp_valid <= 1'b1;
      lbp_addr  <= b_addr;
      lbp_data  <= 8'h00;
    end else begin
      lbp_valid <= 1'b0;
    end
  end

  // Finish is registered so it rises the cycle after the final write is on the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish <= 1'b0;
    end else if (state == S_DONE) begin
      finish <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Bench for lbp_stream_engine: a 5x4 engine without border write-back and a 6x5 engine with it.
// Expected writes are queued when a run is started; negedge monitors pop and compare each write.
module tb_lbp_stream_engine;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       rdy_a, req_a, val_a, fin_a;
  logic [4:0] gaddr_a, laddr_a;
  logic [7:0] gdat_a, ldat_a;
  logic       rdy_b, req_b, val_b, fin_b;
  logic [4:0] gaddr_b, laddr_b;
  logic [7:0] gdat_b, ldat_b;

  logic [7:0] img_a [0:19];
  logic [7:0] img_b [0:29];
  logic [7:0] mem_b [0:29];

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  int   checks = 0;
  int   passed = 0;
  int   n_acc_a = 0;
  int   n_acc_b = 0;
  int   writes_b = 0;
  bit   acc_prev_a = 0;
  bit   exp_v_a;
  logic [4:0] acc_prev_addr_a;

  assign gdat_a = (gaddr_a < 5'd20) ? img_a[gaddr_a] : 8'h00;
  assign gdat_b = (gaddr_b < 5'd30) ? img_b[gaddr_b] : 8'h00;

  lbp_stream_engine #(.IMG_W(5), .IMG_H(4), .PIX_W(8), .ADDR_W(5), .BORDER_WRITE(0)) dut_a (
    .clk(clk), .reset(rst), .gray_ready(rdy_a), .gray_req(req_a), .gray_addr(gaddr_a),
    .gray_data(gdat_a), .lbp_valid(val_a), .lbp_addr(laddr_a), .lbp_data(ldat_a), .finish(fin_a)
  );

  lbp_stream_engine #(.IMG_W(6), .IMG_H(5), .PIX_W(8), .ADDR_W(5), .BORDER_WRITE(1)) dut_b (
    .clk(clk), .reset(rst), .gray_ready(rdy_b), .gray_req(req_b), .gray_addr(gaddr_b),
    .gray_data(gdat_b), .lbp_valid(val_b), .lbp_addr(laddr_b), .lbp_data(ldat_b), .finish(fin_b)
  );

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // Monitor for the 5x4 engine: read order, one-cycle latency, and scoreboard of result writes.
  always @(negedge clk) begin
    if (rst) begin
      n_acc_a    = 0;
      acc_prev_a = 0;
    end else begin
      exp_v_a = acc_prev_a && ((acc_prev_addr_a / 5) >= 2) && ((acc_prev_addr_a % 5) >= 2);
      if (acc_prev_a || val_a) chk(val_a == exp_v_a, "latency_a", int'(val_a), int'(exp_v_a));
      if (val_a) begin
        chk(fin_a == 1'b0, "finish_early_a", int'(fin_a), 0);
        if (q_a.size() == 0) begin
          chk(1'b0, "unexpected_write_a", int'(laddr_a), -1);
        end else begin
          ea = q_a.pop_front();
          chk(laddr_a == ea.addr, "addr_a", int'(laddr_a), int'(ea.addr));
          chk(ldat_a == ea.data, "data_a", int'(ldat_a), int'(ea.data));
        end
      end
      acc_prev_a      = req_a && rdy_a;
      acc_prev_addr_a = gaddr_a;
      if (req_a && rdy_a) begin
        chk(gaddr_a == 5'(n_acc_a), "read_addr_a", int'(gaddr_a), n_acc_a);
        n_acc_a++;
      end
    end
  end

  // Monitor for the 6x5 engine: read order, scoreboard, and a result memory written on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      n_acc_b  = 0;
      writes_b = 0;
    end else begin
      if (val_b) begin
        chk(fin_b == 1'b0, "finish_early_b", int'(fin_b), 0);
        writes_b++;
        if (laddr_b < 5'd30) mem_b[laddr_b] = ldat_b;
        if (q_b.size() == 0) begin
          chk(1'b0, "unexpected_write_b", int'(laddr_b), -1);
        end else begin
          eb = q_b.pop_front();
          chk(laddr_b == eb.addr, "addr_b", int'(laddr_b), int'(eb.addr));
          chk(ldat_b == eb.data, "data_b", int'(ldat_b), int'(eb.data));
        end
      end
      if (req_b && rdy_b) begin
        chk(gaddr_b == 5'(n_acc_b), "read_addr_b", int'(gaddr_b), n_acc_b);
        n_acc_b++;
      end
    end
  end

  task automatic do_reset();
    rst   = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    #1;
    q_a.delete();
    q_b.delete();
    chk(req_a == 1'b0, "rst_req_a", int'(req_a), 0);
    chk(gaddr_a == 5'd0, "rst_gaddr_a", int'(gaddr_a), 0);
    chk(val_a == 1'b0, "rst_valid_a", int'(val_a), 0);
    chk(laddr_a == 5'd0, "rst_laddr_a", int'(laddr_a), 0);
    chk(ldat_a == 8'd0, "rst_ldata_a", int'(ldat_a), 0);
    chk(fin_a == 1'b0, "rst_finish_a", int'(fin_a), 0);
    chk(req_b == 1'b0 && val_b == 1'b0 && fin_b == 1'b0, "rst_outputs_b",
        int'({req_b, val_b, fin_b}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Image kinds for the 5x4 engine: 0 ascending r*5+c, 1 flat 0x40, 2 checker 0x90/0x10, 3 descending.
  task automatic load_a(input int kind);
    for (int i = 0; i < 20; i++) begin
      case (kind)
        0:       img_a[i] = 8'(i);
        1:       img_a[i] = 8'h40;
        2:       img_a[i] = ((((i / 5) + (i % 5)) % 2) == 0) ? 8'h90 : 8'h10;
        default: img_a[i] = 8'(200 - i);
      endcase
    end
  endtask

  // Interior addresses of a 5x4 image in raster order: 6,7,8,11,12,13.
  task automatic push_a(input logic [7:0] d0, d1, d2, d3, d4, d5);
    logic [7:0] d [6];
    int         a [6];
    exp_t       e;
    d = '{d0, d1, d2, d3, d4, d5};
    a = '{6, 7, 8, 11, 12, 13};
    for (int i = 0; i < 6; i++) begin
      e.addr = 5'(a[i]);
      e.data = d[i];
      q_a.push_back(e);
    end
  endtask

  task automatic push_b(input int a, input logic [7:0] d);
    exp_t e;
    e.addr = 5'(a);
    e.data = d;
    q_b.push_back(e);
  endtask

  // Drive gray_ready (mode 0: always, mode 1: one cycle in three) until finish or a cycle budget.
  task automatic run_a(input int mode, input string nm);
    int cyc = 0;
    while (!fin_a && cyc < 400) begin
      rdy_a = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(fin_a == 1'b1, {nm, "_finish"}, int'(fin_a), 1);
    chk(q_a.size() == 0, {nm, "_pending"}, q_a.size(), 0);
    chk(n_acc_a == 20, {nm, "_reads"}, n_acc_a, 20);
    rdy_a = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk(fin_a == 1'b1 && req_a == 1'b0 && val_a == 1'b0, {nm, "_hold"},
        int'({fin_a, req_a, val_a}), 4);
  endtask

  initial begin
    int cyc;
    int aa_left;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      img_b[i] = 8'(i);
      mem_b[i] = 8'hAA;
    end
    #2;

    // Ascending image: every interior pixel sees larger values only in the row below and to the right.
    load_a(0); do_reset(); push_a(8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0); run_a(0, "ascending");
    // Flat image: every neighbour equals the centre.
    load_a(1); do_reset(); push_a(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF); run_a(0, "flat");
    // Checker with values above 0x7F: a 0x90 centre keeps only its diagonals, a 0x10 centre keeps all.
    load_a(2); do_reset(); push_a(8'hA5, 8'hFF, 8'hA5, 8'hFF, 8'hA5, 8'hFF); run_a(0, "checker");
    // Descending image under throttled ready: only the row above and the left neighbour are >= centre.
    load_a(3); do_reset(); push_a(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F); run_a(1, "stall");

    // Source never ready: no requests accepted, no writes, no finish.
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    chk(n_acc_a == 0, "idle_reads", n_acc_a, 0);
    chk(req_a == 1'b0 && fin_a == 1'b0, "idle_outputs", int'({req_a, fin_a}), 0);

    // Reset while the first interior result is on the port, then a clean rerun.
    load_a(0); do_reset(); push_a(8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
    rdy_a = 1'b1;
    cyc   = 0;
    while (n_acc_a < 13 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(n_acc_a == 13, "midrst_reads", n_acc_a, 13);
    chk(val_a == 1'b1 && laddr_a == 5'd6, "midrst_first_out", int'({val_a, laddr_a}), 32 + 6);
    do_reset();
    push_a(8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
    run_a(0, "rerun");

    // 6x5 engine with border write-back over a memory pre-filled with 0xAA.
    do_reset();
    for (int r = 1; r < 4; r++)
      for (int c = 1; c < 5; c++) push_b(r * 6 + c, 8'hF0);
    for (int c = 0; c < 6; c++) push_b(c, 8'h00);
    for (int r = 1; r < 4; r++) begin
      push_b(r * 6, 8'h00);
      push_b(r * 6 + 5, 8'h00);
    end
    for (int c = 0; c < 6; c++) push_b(24 + c, 8'h00);
    cyc = 0;
    while (!fin_b && cyc < 400) begin
      rdy_b = (n_acc_b < 30);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(fin_b == 1'b1, "border_finish", int'(fin_b), 1);
    chk(q_b.size() == 0, "border_pending", q_b.size(), 0);
    chk(n_acc_b == 30, "border_reads", n_acc_b, 30);
    chk(writes_b == 30, "border_writes", writes_b, 30);
    aa_left = 0;
    for (int i = 0; i < 30; i++) if (mem_b[i] == 8'hAA) aa_left++;
    chk(aa_left == 0, "border_aa_left", aa_left, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
